// File: rtl/decode_pkg.sv
// Shared types and helpers for the multi-lane decode stage.
package decode_pkg;

   localparam int INSTR_W = 27;
   localparam int REG_AW  = 4;

   // First register that needs supervisor privilege to access.
   localparam logic [REG_AW-1:0] PRIV_REG_BASE = 4'd14;

   typedef struct packed {
      logic              upper_shiftmode;
      logic              aui_mode;
      logic              use_upper_imm;
      logic              m_format;
      logic [3:0]        funccode;
      logic              use_imm;
      logic              is_mem;
      logic              mem_write;
      logic              is_jump;
      logic [3:0]        aluop;
      logic [REG_AW-1:0] ra_d;
      logic [REG_AW-1:0] ra_m;
      logic [REG_AW-1:0] ra_a;
      logic [REG_AW-1:0] ra_b;
      logic [20:0]       upper_imm;
      logic [10:0]       lower_imm;
      logic              priv;
   } decoded_t;

   localparam int DEC_W = $bits(decoded_t);

   function automatic logic reg_priv(input logic [REG_AW-1:0] addr);
      return addr < PRIV_REG_BASE;
   endfunction

endpackage

// File: rtl/decode_lane.sv
// Combinational single-lane instruction decoder.
module decode_lane
   import decode_pkg::*;
(
   input  logic [INSTR_W-1:0] instr,
   output decoded_t           dec
);

   logic [1:0] basecode;
   logic [1:0] subcode;

   assign basecode = instr[22:21];
   assign subcode  = {instr[20], instr[11]};

   always_comb begin
      dec = '0;
      dec.upper_shiftmode = basecode[1];
      dec.aui_mode        = basecode[0];
      dec.use_upper_imm   = |basecode;
      dec.m_format        = ~(|basecode) & (subcode == 2'b11);
      dec.funccode        = dec.m_format ? instr[26:23]
                                         : instr[19:16];
      dec.use_imm         = dec.use_upper_imm | dec.funccode[3];
      dec.is_mem          = ~dec.use_upper_imm & subcode[1]
                          & dec.funccode[2]
                          & (dec.funccode[1:0] != 2'b11);
      dec.mem_write       = dec.is_mem & dec.m_format;
      dec.is_jump         = (basecode == 2'b01)
                          | ((basecode == 2'b00)
                             & (subcode == 2'b10)
                             & (dec.funccode[2:0] == 3'b111));
      dec.aluop           = dec.use_upper_imm ? 4'd0
                          : {subcode[1], dec.funccode[2:0]};
      dec.ra_d            = dec.m_format ? 4'd0 : instr[26:23];
      dec.ra_m            = dec.m_format ? instr[19:16] : 4'd0;
      dec.ra_a            = dec.use_upper_imm ? 4'd0 : instr[15:12];
      dec.ra_b            = dec.use_imm ? 4'd0 : instr[3:0];
      dec.upper_imm       = instr[20:0];
      dec.lower_imm       = instr[10:0];
      // Zeroed register fields read r0, which is always accessible.
      dec.priv            = reg_priv(dec.ra_d) & reg_priv(dec.ra_m)
                          & reg_priv(dec.ra_a) & reg_priv(dec.ra_b);
   end

endmodule

// File: rtl/decode_stage.sv
// Multi-lane decode stage with a DEPTH-entry bundle FIFO toward issue.
module decode_stage
   import decode_pkg::*;
#(
   parameter int LANES = 1,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [INSTR_W*LANES-1:0]   in_instr,
   input  logic [LANES-1:0]           in_lane_valid,
   input  logic                       priv_in,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output decoded_t [LANES-1:0]       out_dec,
   output logic [LANES-1:0]           out_lane_valid,
   output logic [LANES-1:0]           out_fault,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   decoded_t [LANES-1:0] dec_lane;
   decoded_t [LANES-1:0] dec_in;
   logic     [LANES-1:0] flt_in;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      decode_lane u_lane (
         .instr (in_instr[INSTR_W*g +: INSTR_W]),
         .dec   (dec_lane[g])
      );
      assign dec_in[g] = in_lane_valid[g] ? dec_lane[g] : '0;
      assign flt_in[g] = in_lane_valid[g] & ~dec_lane[g].priv
                       & ~priv_in;
   end

   decoded_t [LANES-1:0] dec_mem [DEPTH];
   logic     [LANES-1:0] lv_mem  [DEPTH];
   logic     [LANES-1:0] flt_mem [DEPTH];

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          full;
   logic          push;
   logic          pop;

   assign full      = (count == CW'(DEPTH));
   assign in_ready  = ~full;
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         dec_mem[wr_ptr] <= dec_in;
         lv_mem[wr_ptr]  <= in_lane_valid;
         flt_mem[wr_ptr] <= flt_in;
      end
   end

   // Storage is not reset, so an empty FIFO presents zeros.
   assign out_dec        = out_valid ? dec_mem[rd_ptr] : '0;
   assign out_lane_valid = out_valid ? lv_mem[rd_ptr]  : '0;
   assign out_fault      = out_valid ? flt_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage with a queue-based reference model.
module tb_decode_stage;
   import decode_pkg::*;

   localparam int LANES = 2;
   localparam int DEPTH = 2;
   localparam int CW    = $clog2(DEPTH+1);

   typedef struct packed {
      logic [LANES*DEC_W-1:0] dec;
      logic [LANES-1:0]       lv;
      logic [LANES-1:0]       flt;
   } entry_t;

   logic                   clk = 0;
   logic                   rst;
   logic                   in_valid;
   logic                   in_ready;
   logic [INSTR_W*LANES-1:0] in_instr;
   logic [LANES-1:0]       in_lane_valid;
   logic                   priv_in;
   logic                   flush;
   logic                   out_valid;
   logic                   out_ready;
   decoded_t [LANES-1:0]   out_dec;
   logic [LANES-1:0]       out_lane_valid;
   logic [LANES-1:0]       out_fault;
   logic [CW-1:0]          count;

   int n_pass = 0;
   int n_total = 0;
   bit done = 0;
   entry_t q[$];

   decode_stage #(.LANES(LANES), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_lane_valid(in_lane_valid),
      .priv_in(priv_in), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_dec(out_dec), .out_lane_valid(out_lane_valid),
      .out_fault(out_fault), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [159:0] got,
                      input logic [159:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   function automatic int fld(input logic [26:0] w, input int lsb,
                              input int n);
      return int'(32'(w) >> lsb) & ((1 << n) - 1);
   endfunction

   function automatic bit ok_reg(input int r);
      return r < 14;
   endfunction

   function automatic decoded_t mdec(input logic [26:0] w);
      decoded_t d;
      int base, sub, fc, rd, rm, ra, rb;
      bit up, mf;
      d    = '0;
      base = fld(w, 21, 2);
      sub  = fld(w, 20, 1) * 2 + fld(w, 11, 1);
      up   = base != 0;
      mf   = !up && sub == 3;
      fc   = mf ? fld(w, 23, 4) : fld(w, 16, 4);
      d.upper_shiftmode = base >= 2;
      d.aui_mode        = base % 2 == 1;
      d.use_upper_imm   = up;
      d.m_format        = mf;
      d.funccode        = 4'(fc);
      d.use_imm         = up || fc >= 8;
      d.is_mem          = !up && sub >= 2 && (fc % 8) >= 4
                          && (fc % 4) != 3;
      d.mem_write       = d.is_mem && mf;
      d.is_jump         = base == 1 || (base == 0 && sub == 2
                                        && fc % 8 == 7);
      d.aluop           = up ? 4'd0 : 4'((sub / 2) * 8 + fc % 8);
      rd = mf ? 0 : fld(w, 23, 4);
      rm = mf ? fld(w, 16, 4) : 0;
      ra = up ? 0 : fld(w, 12, 4);
      rb = d.use_imm ? 0 : fld(w, 0, 4);
      d.ra_d = 4'(rd);
      d.ra_m = 4'(rm);
      d.ra_a = 4'(ra);
      d.ra_b = 4'(rb);
      d.upper_imm = 21'(fld(w, 0, 21));
      d.lower_imm = 11'(fld(w, 0, 11));
      d.priv = ok_reg(rd) && ok_reg(rm) && ok_reg(ra) && ok_reg(rb);
      return d;
   endfunction

   function automatic entry_t mk_entry();
      entry_t e;
      decoded_t d;
      e = '0;
      for (int i = 0; i < LANES; i++) begin
         if (in_lane_valid[i]) begin
            d = mdec(in_instr[INSTR_W*i +: INSTR_W]);
            e.dec[DEC_W*i +: DEC_W] = d;
            e.lv[i]  = 1'b1;
            e.flt[i] = !d.priv && !priv_in;
         end
      end
      return e;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) q.delete();
      else if (flush) q.delete();
      else begin
         automatic bit was_full  = q.size() == DEPTH;
         automatic bit was_empty = q.size() == 0;
         if (!was_empty && out_ready) void'(q.pop_front());
         if (in_valid && !was_full) q.push_back(mk_entry());
      end
   end

   always @(posedge clk) begin
      #4;
      if (!done) begin
         chk("count", 160'(count), 160'(q.size()));
         chk("out_valid", 160'(out_valid), 160'(q.size() != 0));
         chk("in_ready", 160'(in_ready), 160'(q.size() < DEPTH));
         if (q.size() != 0) begin
            chk("out_dec", 160'(out_dec), 160'(q[0].dec));
            chk("out_lane_valid", 160'(out_lane_valid), 160'(q[0].lv));
            chk("out_fault", 160'(out_fault), 160'(q[0].flt));
         end
      end
   end

   task automatic drive(input logic v, input logic [53:0] ins,
                        input logic [1:0] lm, input logic p,
                        input logic fl, input logic ordy);
      @(negedge clk);
      in_valid = v; in_instr = ins; in_lane_valid = lm;
      priv_in = p; flush = fl; out_ready = ordy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   decoded_t l1, l2;

   initial begin
      rst = 1; in_valid = 0; in_instr = '0; in_lane_valid = '0;
      priv_in = 0; flush = 0; out_ready = 0;

      l1 = '0;
      l1.aui_mode = 1; l1.use_upper_imm = 1; l1.use_imm = 1;
      l1.is_jump = 1; l1.priv = 1;
      l2 = '0;
      l2.m_format = 1; l2.funccode = 4'h4; l2.is_mem = 1;
      l2.mem_write = 1; l2.aluop = 4'hC; l2.ra_m = 4'd3;
      l2.ra_a = 4'd2; l2.ra_b = 4'd1; l2.upper_imm = 21'h132801;
      l2.lower_imm = 11'h001; l2.priv = 1;
      chk("model_l1", 160'(mdec(27'h0200000)), 160'(l1));
      chk("model_l2", 160'(mdec(27'h2132801)), 160'(l2));

      #3;
      chk("rst_out_valid", 160'(out_valid), 160'(0));
      chk("rst_in_ready", 160'(in_ready), 160'(1));
      chk("rst_count", 160'(count), 160'(0));
      chk("rst_out_dec", 160'(out_dec), 160'(0));
      chk("rst_fault", 160'(out_fault), 160'(0));
      @(negedge clk) rst = 0;

      drive(1, {27'h0, 27'h0200000}, 2'b01, 1, 0, 0);
      tick();
      chk("lat_valid", 160'(out_valid), 160'(1));
      chk("jump_dec", 160'(out_dec[0]), 160'(l1));
      chk("jump_lv", 160'(out_lane_valid), 160'(2'b01));
      chk("jump_lane1", 160'(out_dec[1]), 160'(0));

      drive(0, '0, 2'b00, 1, 0, 1);
      drive(1, {27'h0, 27'h2132801}, 2'b01, 1, 0, 0);
      tick();
      chk("mem_dec", 160'(out_dec[0]), 160'(l2));

      drive(1, {27'h1234567, 27'h0765432}, 2'b11, 1, 0, 0);
      tick();
      chk("full_ready", 160'(in_ready), 160'(0));
      chk("full_count", 160'(count), 160'(2));
      drive(1, {27'h7654321, 27'h0111111}, 2'b11, 1, 0, 0);
      tick();
      chk("refused_count", 160'(count), 160'(2));
      chk("order_head", 160'(out_dec[0]), 160'(l2));
      drive(0, '0, 2'b00, 1, 0, 1);
      tick();
      chk("pop_ready", 160'(in_ready), 160'(1));
      chk("pop_head", 160'(out_dec[0]), 160'(mdec(27'h0765432)));

      drive(1, {27'h0, 27'h0200000}, 2'b01, 1, 1, 0);
      tick();
      chk("flush_count", 160'(count), 160'(0));
      chk("flush_valid", 160'(out_valid), 160'(0));
      drive(0, '0, 2'b00, 1, 0, 0);
      tick();
      chk("flush_lost", 160'(out_valid), 160'(0));

      drive(1, {27'h000F000, 27'h000F000}, 2'b01, 0, 0, 0);
      tick();
      chk("fault_user", 160'(out_fault), 160'(2'b01));
      chk("fault_inv_dec", 160'(out_dec[1]), 160'(0));
      drive(1, {27'h000F000, 27'h000F000}, 2'b01, 1, 0, 1);
      tick();
      chk("fault_sup", 160'(out_fault), 160'(2'b00));
      chk("pushpop_count", 160'(count), 160'(1));

      drive(1, {27'h0, 27'h2132801}, 2'b01, 1, 0, 0);
      tick();
      chk("pre_rst_count", 160'(count), 160'(2));
      @(negedge clk) in_valid = 0;
      @(posedge clk);
      #2 rst = 1;
      #1;
      chk("async_valid", 160'(out_valid), 160'(0));
      chk("async_count", 160'(count), 160'(0));
      chk("async_ready", 160'(in_ready), 160'(1));
      chk("async_dec", 160'(out_dec), 160'(0));
      @(negedge clk);
      rst = 0; in_valid = 1; in_lane_valid = 2'b10;
      in_instr = {27'h2132801, 27'h0};
      #1 chk("rel_ready", 160'(in_ready), 160'(1));
      tick();
      chk("rel_valid", 160'(out_valid), 160'(1));
      chk("rel_dec", 160'(out_dec[1]), 160'(l2));

      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         in_valid      = $urandom_range(0, 3) != 0;
         in_instr      = {27'($urandom), 27'($urandom)};
         in_lane_valid = 2'($urandom);
         priv_in       = 1'($urandom);
         flush         = $urandom_range(0, 15) == 0;
         out_ready     = $urandom_range(0, 2) != 0;
      end
      @(negedge clk);
      in_valid = 0; flush = 0;
      tick();
      #5;
      done = 1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
# decode_stage

Buffered, multi-lane instruction decode stage between fetch and register read. Each cycle it accepts a bundle of up to LANES 27-bit instructions over a valid/ready handshake and decodes every lane through a per-lane combinational decoder. It tags each lane with a privilege fault and stores the decoded bundle in a DEPTH-entry FIFO feeding issue. Flush support lets redirects discard in-flight bundles.

## Interface
- LANES, 1: instructions per bundle (1..4).
- DEPTH, 2: FIFO entries (power of two, ≥2).
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  bundle offered.
- in_ready  out  1  bundle accepted when in_valid & in_ready.
- in_instr  in  27*LANES  lane i at bits [27i+26:27i].
- in_lane_valid  in  LANES  per-lane valid mask.
- priv_in  in  1  current privilege level, sampled at accept.
- flush  in  1  discard all stored and incoming bundles.
- out_valid  out  1  head bundle present.
- out_ready  in  1  consumer takes head when out_valid & out_ready.
- out_dec  out  LANES x decoded_t  head bundle decoded fields.
- out_lane_valid  out  LANES  head bundle lane mask.
- out_fault  out  LANES  per-lane privilege fault.
- count  out  $clog2(DEPTH+1)  occupancy.

## Operation
- Per-lane decode, with instr = lane word:
  - basecode = instr[22:21], subcode = {instr[20], instr[11]}.
  - upper_shiftmode = basecode[1], aui_mode = basecode[0], use_upper_imm = either.
  - m_format = ~use_upper_imm & subcode==2'b11.
  - funccode = m_format ? instr[26:23] : instr[19:16].
  - use_imm = use_upper_imm | funccode[3].
  - is_mem = ~use_upper_imm & subcode[1] & funccode[2] & funccode[1:0]!=2'b11; mem_write = is_mem & m_format.
  - is_jump = basecode==01 | (basecode==00 & subcode==10 & funccode[2:0]==3'b111).
  - aluop = use_upper_imm ? 0 : {subcode[1], funccode[2:0]}.
  - ra_d = m_format ? 0 : instr[26:23]; ra_m = m_format ? instr[19:16] : 0.
  - ra_a = use_upper_imm ? 0 : instr[15:12]; ra_b = use_imm ? 0 : instr[3:0].
  - upper_imm = instr[20:0], lower_imm = instr[10:0].
  - priv = AND of reg_priv() over ra_d, ra_m, ra_a, ra_b.
- fault[i] = in_lane_valid[i] & ~priv[i] & ~priv_in, computed at accept and stored with the entry.
- Invalid lanes are stored with decoded fields forced to 0 and fault 0.
- FIFO: push on accept, pop on out_valid & out_ready, in order.
- in_ready = ~full. It has no combinational dependence on out_ready; push is refused when full, even with a simultaneous pop.
- out_valid = count != 0. out_* present the head entry directly from storage.
- Simultaneous push and pop when 0 < count < DEPTH: count unchanged.
- flush: next edge count = 0 and pointers = 0. A push or pop in the same cycle is discarded; flush wins.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (async assert): count = 0, pointers = 0, out_valid = 0, in_ready = 1, out_dec/out_lane_valid/out_fault = 0.
- Latency: a bundle accepted at edge N is visible on out_* after edge N (out_valid high in cycle N+1) when the FIFO was empty.
- No bypass from in_* to out_*; all outputs are register or storage driven.
- out_* are held stable while out_valid & ~out_ready.
- Reset mid-operation drops all entries immediately; in_ready is 1 in the first cycle after deassertion.

## Structure
- Package decode_pkg: decoded_t (packed fields above), INSTR_W = 27, REG_AW = 4, function reg_priv(addr) shared with the existing privilege table.
- Sub-module decode_lane: combinational single-lane decoder producing decoded_t, instantiated LANES times.
- FIFO storage and control live in decode_stage.

## Test plan
- LANES=1, instr 0x0200000 pushed into empty FIFO -> next cycle out_valid=1; is_jump=1, aui_mode=1, use_upper_imm=1, use_imm=1, aluop=0, all ra=0.
- instr 0x2132801 -> m_format, is_mem=1, mem_write=1, aluop=0xC, ra_m=3, ra_a=2, ra_b=1, ra_d=0, lower_imm=0x001.
- DEPTH=2, out_ready=0, three pushes -> third refused (in_ready=0, count=2); one pop -> in_ready=1; order preserved.
- count=1, flush with in_valid=1 same cycle -> count=0, out_valid=0, pushed bundle lost.
- Non-privileged register on ra_a with priv_in=0 -> out_fault=1; same instr with priv_in=1 -> out_fault=0; invalid lane -> fault 0.
- rst asserted mid-stream with count=2 -> outputs zero immediately without a clock edge; first push after release appears one cycle later.
